// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    localparam int unsigned     BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when a nibble holds a legal decimal digit.
    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of add or nine's-complement subtract with decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_d,
    input  logic [BCD_W-1:0] b_d,
    input  logic             cin,
    input  logic             sub,
    output logic [BCD_W-1:0] sum_d,
    output logic             cout
);

    logic [BCD_W-1:0] w_b_adj;
    logic [BCD_W:0]   w_s;

    // Nine's-complement B for subtract (mod 16 for illegal digits), then binary sum and >=10 correction.
    always_comb begin
        w_b_adj = sub ? BCD_W'(BCD_MAX - b_d) : b_d;
        w_s     = {1'b0, a_d} + {1'b0, w_b_adj} + {{BCD_W{1'b0}}, cin};
        sum_d   = w_s[BCD_W-1:0];
        cout    = 1'b0;
        if (w_s >= (BCD_W+1)'(10)) begin
            sum_d = BCD_W'(w_s - (BCD_W+1)'(10));
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first, valid/ready on both sides.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGITS*BCD_W-1:0]   a,
    input  logic [DIGITS*BCD_W-1:0]   b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGITS*BCD_W-1:0]   result,
    output logic                      cout,
    output logic                      err
);

    localparam int unsigned W     = DIGITS * BCD_W;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic [IDX_W-1:0] r_idx;
    logic             r_sub;
    logic             r_c;
    logic             r_cout;
    logic             r_err;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_err;
    logic [BCD_W-1:0] w_sum;
    logic             w_dcout;

    // Single digit adder fed from the low nibble of the shifting operand registers.
    bcd_digit_add u_digit (
        .a_d   (r_a[BCD_W-1:0]),
        .b_d   (r_b[BCD_W-1:0]),
        .cin   (r_c),
        .sub   (r_sub),
        .sum_d (w_sum),
        .cout  (w_dcout)
    );

    // Flag any illegal nibble in either incoming operand.
    always_comb begin
        w_err = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (!is_bcd(a[k*BCD_W +: BCD_W]) || !is_bcd(b[k*BCD_W +: BCD_W])) begin
                w_err = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, serial digit processing and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_c         <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            r_in_ready  <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_sub <= sub;
                r_c   <= sub;
                r_idx <= '0;
                r_err <= w_err;
            end
            if (w_step) begin
                r_a   <= r_a >> BCD_W;
                r_b   <= r_b >> BCD_W;
                r_c   <= w_dcout;
                r_idx <= IDX_W'(r_idx + 1'b1);
                r_result[r_idx*BCD_W +: BCD_W] <= w_sum;
                if (w_last) begin
                    r_cout <= r_sub ? ~w_dcout : w_dcout;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomised self-checking bench for bcd_serial_addsub against a decimal-arithmetic model.
module tb_bcd_serial_addsub;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = DIGITS * 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    typedef struct packed {
        logic [W-1:0] r;
        logic         co;
        logic         er;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome: decimal arithmetic for legal operands, the per-digit rule otherwise.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        exp_t            e;
        longint unsigned va, vb, m, r;
        int              t, c, na, nb;
        e = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (av[i*4 +: 4] > 4'd9 || bv[i*4 +: 4] > 4'd9) e.er = 1'b1;
        end
        if (!e.er) begin
            va = 0; vb = 0; m = 1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                va = va * 10 + 64'(av[i*4 +: 4]);
                vb = vb * 10 + 64'(bv[i*4 +: 4]);
                m  = m * 10;
            end
            if (!s) begin
                r    = va + vb;
                e.co = (r >= m);
                r    = r % m;
            end else begin
                e.co = (va < vb);
                r    = (va + m - vb) % m;
            end
            for (int i = 0; i < DIGITS; i++) begin
                e.r[i*4 +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end else begin
            c = s ? 1 : 0;
            for (int i = 0; i < DIGITS; i++) begin
                na = int'(av[i*4 +: 4]);
                nb = int'(bv[i*4 +: 4]);
                if (s) nb = (9 - nb) & 15;
                t = na + nb + c;
                if (t >= 10) begin
                    e.r[i*4 +: 4] = 4'(t - 10);
                    c = 1;
                end else begin
                    e.r[i*4 +: 4] = 4'(t);
                    c = 0;
                end
            end
            e.co = s ? (c == 0) : (c == 1);
        end
        return e;
    endfunction

    // Output compare: every cycle a result is presented, check it against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                chk("result", 64'(result), 64'(exp_q[0].r));
                chk("cout", 64'(cout), 64'(exp_q[0].co));
                chk("err", 64'(err), 64'(exp_q[0].er));
                chk("in_ready_busy", 64'(in_ready), 64'(0));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Hand-computed pins on the model itself.
    task automatic pin(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                       input logic [W-1:0] r, input logic co, input logic er);
        exp_t e;
        e = model(av, bv, s);
        chk("pin_result", 64'(e.r), 64'(r));
        chk("pin_cout", 64'(e.co), 64'(co));
        chk("pin_err", 64'(e.er), 64'(er));
    endtask

    // One full transaction; hold>0 stalls the consumer for that many cycles after out_valid rises.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input int hold);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("idle_ready", 64'(in_ready), 64'(1));
        a = av; b = bv; sub = s;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(av, bv, s));
        chk("accepted", 64'(in_ready), 64'(0));
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(DIGITS));
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom); sub = ~s;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff_out_valid", 64'(out_valid), 64'(0));
        chk("handoff_in_ready", 64'(in_ready), 64'(1));
    endtask

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && ($urandom_range(0, 3) == 0)) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        pin(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        pin(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        pin(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0);
        pin(16'h0012, 16'h0034, 1'b1, 16'h9978, 1'b1, 1'b0);
        pin(16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b0, 1'b0);
        pin(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);

        run_op(16'h1234, 16'h5678, 1'b0, 0);
        run_op(16'h9999, 16'h0001, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 0);
        run_op(16'h5000, 16'h1234, 1'b1, 0);
        run_op(16'h0012, 16'h0034, 1'b1, 0);
        run_op(16'h0007, 16'h0007, 1'b1, 0);
        run_op(16'h00A0, 16'h0000, 1'b0, 0);
        run_op(16'h4321, 16'h8765, 1'b0, 3);

        // Reset asserted for one edge during the second RUN cycle.
        a = 16'h2222; b = 16'h3333; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_result", 64'(result), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        run_op(16'h0001, 16'h0002, 1'b0, 0);

        for (int n = 0; n < 80; n++) begin
            bit bad;
            int hold;
            bad  = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(rand_operand(bad), rand_operand(bad), 1'($urandom_range(0, 1)), hold);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
